// File: rtl/fetch_unit.sv
// fetch_unit: reads 32-bit words from the shared RAM over a req/ack handshake,
// splits each word into two 16-bit instructions and queues them, each tagged
// with its own PC, in a small halfword prefetch FIFO feeding the decoder.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_mem_req,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_data,
  output logic [15:0] o_ir,
  output logic [31:0] o_ir_pc,
  output logic        o_ir_valid,
  input  logic        i_ir_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] START_PC = RESET_PC & ~32'd1;

  typedef enum logic {S_FETCH, S_DISCARD} state_t;

  state_t          r_state;
  logic [31:0]     r_fetch_pc;
  logic            r_req;
  logic [31:0]     r_addr;
  logic [CW-1:0]   r_count;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [15:0]     r_data [DEPTH];
  logic [31:0]     r_hpc  [DEPTH];

  state_t          w_state_nxt;
  logic [31:0]     w_pc_nxt;
  logic            w_ack;
  logic            w_hold;
  logic            w_pop;
  logic            w_push;
  logic            w_push2;
  logic [CW-1:0]   w_push_cnt;
  logic [CW-1:0]   w_count_nxt;
  logic [CW-1:0]   w_free;
  logic [CW-1:0]   w_need;
  logic            w_req_nxt;
  logic [31:0]     w_addr_nxt;
  logic [AW-1:0]   w_wr_next1;
  logic [AW-1:0]   w_wr_step;

  // Handshake decode, FIFO occupancy and the next request decision.
  always_comb begin
    w_ack       = r_req & i_mem_ack;
    w_hold      = r_req & ~i_mem_ack;
    w_pop       = (r_count != '0) & i_ir_ready;
    w_push      = (r_state == S_FETCH) & w_ack & ~i_redirect;
    w_push2     = w_push & ~r_fetch_pc[1];
    w_push_cnt  = w_push2 ? CW'(2) : (w_push ? CW'(1) : CW'(0));
    w_count_nxt = i_redirect ? '0 : (r_count + w_push_cnt - CW'(w_pop));
    w_free      = CW'(DEPTH) - w_count_nxt;
    // An odd-halfword start only pushes the upper half, so one slot suffices.
    w_need      = w_pc_nxt[1] ? CW'(1) : CW'(2);
    // Space is reserved against the post-update count, so an ack can never overflow.
    w_req_nxt   = w_hold | ((w_state_nxt == S_FETCH) & (w_free >= w_need));
    w_addr_nxt  = w_hold ? r_addr : {w_pc_nxt[31:2], 2'b00};
    w_wr_next1  = r_wr_ptr + AW'(1);
    w_wr_step   = w_push2 ? AW'(2) : AW'(1);
  end

  // Next-state and next fetch PC; a redirect under an outstanding read must
  // wait for that read's ack before the new stream may start.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_fetch_pc;
    case (r_state)
      S_FETCH: begin
        if (i_redirect) begin
          w_pc_nxt = i_redirect_pc & ~32'd1;
          if (w_hold) w_state_nxt = S_DISCARD;
        end else if (w_ack) begin
          w_pc_nxt = {r_fetch_pc[31:2] + 30'd1, 2'b00};
        end
      end
      S_DISCARD: begin
        if (i_redirect) w_pc_nxt = i_redirect_pc & ~32'd1;
        if (w_ack)      w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Control state: FSM, fetch PC, bus request and FIFO pointers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state    <= S_FETCH;
      r_fetch_pc <= START_PC;
      r_req      <= 1'b0;
      r_addr     <= {RESET_PC[31:2], 2'b00};
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
      r_count    <= w_count_nxt;
      if (i_redirect) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + w_wr_step;
      end
    end
  end

  // FIFO storage: one or two halfwords per accepted word, each with its PC.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
        r_hpc[i]  <= '0;
      end
    end else if (w_push) begin
      if (w_push2) begin
        r_data[r_wr_ptr]   <= i_mem_data[15:0];
        r_hpc[r_wr_ptr]    <= {r_fetch_pc[31:2], 2'b00};
        r_data[w_wr_next1] <= i_mem_data[31:16];
        r_hpc[w_wr_next1]  <= {r_fetch_pc[31:2], 2'b10};
      end else begin
        r_data[r_wr_ptr]   <= i_mem_data[31:16];
        r_hpc[r_wr_ptr]    <= {r_fetch_pc[31:2], 2'b10};
      end
    end
  end

  assign o_mem_req  = r_req;
  assign o_mem_addr = r_addr;
  assign o_ir_valid = (r_count != '0);
  assign o_ir       = r_data[r_rd_ptr];
  assign o_ir_pc    = r_hpc[r_rd_ptr];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: a RAM model answers requests with random timing, and the
// delivered instruction stream is compared with the PC sequence implied by
// reset and redirects.
module tb_fetch_unit;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_mem_req;
  logic [31:0] o_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic [15:0] o_ir;
  logic [31:0] o_ir_pc;
  logic        o_ir_valid;
  logic        i_ir_ready = 1'b0;

  fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_mem_req(o_mem_req), .o_mem_addr(o_mem_addr), .i_mem_ack(i_mem_ack),
    .i_mem_data(i_mem_data), .o_ir(o_ir), .o_ir_pc(o_ir_pc), .o_ir_valid(o_ir_valid),
    .i_ir_ready(i_ir_ready)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        redir;
    logic [31:0] pc;
    logic [15:0] ir;
  } ev_t;

  int tests = 0, fails = 0;
  int ack_pct = 100, rdy_pct = 100;
  bit dforce = 0;
  logic [31:0] dval = '0;
  ev_t evq[$];
  logic [31:0] ackq[$];
  logic [31:0] m_pc = 32'h0;
  bit p_hold_req = 0, p_hold_ir = 0;
  logic [31:0] p_addr, p_ir_pc;
  logic [15:0] p_ir;
  int req_hold_err = 0, align_err = 0, ir_hold_err = 0;
  bit seen_valid = 0;
  int bubbles = 0;

  // RAM contents: every halfword is a function of its own address (top bit 0).
  function automatic logic [15:0] mem_half(input logic [31:0] a);
    return {1'b0, a[15:1] ^ a[30:16]};
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {mem_half(a + 32'd2), mem_half(a)};
  endfunction

  // One clock: observe outputs, drive the next inputs, record pops/acks/redirects.
  task automatic tick(input bit redir, input logic [31:0] rpc);
    ev_t e;
    if (p_hold_req && (o_mem_req !== 1'b1 || o_mem_addr !== p_addr)) req_hold_err++;
    if (o_mem_req && o_mem_addr[1:0] !== 2'b00) align_err++;
    if (p_hold_ir && (o_ir_valid !== 1'b1 || o_ir !== p_ir || o_ir_pc !== p_ir_pc)) ir_hold_err++;
    if (o_ir_valid) seen_valid = 1;
    else if (seen_valid) bubbles++;
    i_ir_ready    = ($urandom_range(99) < rdy_pct);
    i_mem_ack     = ($urandom_range(99) < ack_pct);
    i_mem_data    = dforce ? dval : mem_word(o_mem_addr);
    i_redirect    = redir;
    i_redirect_pc = rpc;
    if (o_ir_valid && i_ir_ready) begin
      e.redir = 1'b0; e.pc = o_ir_pc; e.ir = o_ir; evq.push_back(e);
    end
    if (redir) begin
      e.redir = 1'b1; e.pc = rpc; e.ir = 16'h0; evq.push_back(e);
    end
    if (o_mem_req && i_mem_ack) ackq.push_back(o_mem_addr);
    p_hold_req = o_mem_req && !i_mem_ack;
    p_addr     = o_mem_addr;
    p_hold_ir  = o_ir_valid && !i_ir_ready && !redir;
    p_ir       = o_ir;
    p_ir_pc    = o_ir_pc;
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  // Fill the FIFO with the consumer stalled until the bus goes idle.
  task automatic go_idle();
    rdy_pct = 0; ack_pct = 100;
    for (int i = 0; i < 20 && o_mem_req; i++) tick(0, 32'h0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge i_clk);
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", o_mem_req); end
    tests++; if (o_mem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", o_mem_addr); end
    tests++; if (o_ir !== 16'h0) begin fails++; $display("FAIL reset_ir: got %h want 0", o_ir); end
    tests++; if (o_ir_pc !== 32'h0) begin fails++; $display("FAIL reset_ir_pc: got %h want 0", o_ir_pc); end
    tests++; if (o_ir_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_ir_valid); end
    m_pc = 32'h0;
    i_rst = 1'b1;
  endtask

  task automatic test_sequential();
    ev_t ev;
    int n = 0;
    ack_pct = 100; rdy_pct = 100; seen_valid = 0; bubbles = 0;
    ackq.delete();
    repeat (40) tick(0, 32'h0);
    for (int i = 0; i < ackq.size(); i++) begin
      tests++;
      if (ackq[i] !== 32'(i * 4)) begin fails++; $display("FAIL seq_addr[%0d]: got %h want %h", i, ackq[i], 32'(i * 4)); end
    end
    tests++; if (bubbles != 0) begin fails++; $display("FAIL seq_bubbles: got %0d want 0", bubbles); end
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++; n++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL seq_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
    tests++; if (n < 30) begin fails++; $display("FAIL seq_throughput: got %0d pops want >=30", n); end
  endtask

  task automatic test_backpressure();
    ev_t ev;
    go_idle();
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL bp_idle: got req %b want 0", o_mem_req); end
    tick(1, 32'h80);
    ackq.delete();
    repeat (20) tick(0, 32'h0);
    tests++; if (ackq.size() != 2) begin fails++; $display("FAIL bp_words: got %0d acked words want 2", ackq.size()); end
    tests++; if (o_mem_req !== 1'b0) begin fails++; $display("FAIL bp_req_full: got %b want 0", o_mem_req); end
    tests++; if (o_ir_valid !== 1'b1 || o_ir_pc !== 32'h80) begin
      fails++; $display("FAIL bp_head: got valid=%b pc=%h want 1/00000080", o_ir_valid, o_ir_pc); end
    tests++; if (ir_hold_err != 0) begin fails++; $display("FAIL bp_ir_stable: got %0d changes want 0", ir_hold_err); end
    rdy_pct = 100;
    repeat (20) tick(0, 32'h0);
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL bp_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
  endtask

  task automatic test_redirect_odd();
    ev_t ev;
    go_idle();
    ack_pct = 0;
    tick(1, 32'h0000_0102);
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h100) begin
      fails++; $display("FAIL odd_req: got req=%b addr=%h want 1/00000100", o_mem_req, o_mem_addr); end
    tests++; if (o_ir_valid !== 1'b0) begin fails++; $display("FAIL odd_flush: got valid %b want 0", o_ir_valid); end
    ack_pct = 100; rdy_pct = 0;
    tick(0, 32'h0);
    tests++; if (o_ir_valid !== 1'b1 || o_ir_pc !== 32'h102 || o_ir !== mem_half(32'h102)) begin
      fails++; $display("FAIL odd_first: got valid=%b pc=%h ir=%h want 1/00000102/%h", o_ir_valid, o_ir_pc, o_ir, mem_half(32'h102)); end
    rdy_pct = 100;
    repeat (10) tick(0, 32'h0);
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL odd_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
  endtask

  task automatic test_discard();
    ev_t ev;
    go_idle();
    ack_pct = 0;
    tick(1, 32'h20);
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h20) begin
      fails++; $display("FAIL disc_req: got req=%b addr=%h want 1/00000020", o_mem_req, o_mem_addr); end
    tick(1, 32'h40);
    for (int i = 0; i < 2; i++) begin
      tick(0, 32'h0);
      tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h20 || o_ir_valid !== 1'b0) begin
        fails++; $display("FAIL disc_hold%0d: got req=%b addr=%h valid=%b want 1/00000020/0", i, o_mem_req, o_mem_addr, o_ir_valid); end
    end
    dforce = 1; dval = 32'hDEAD_BEEF; ack_pct = 100; rdy_pct = 100;
    tick(0, 32'h0);
    dforce = 0;
    tests++; if (o_ir_valid !== 1'b0) begin fails++; $display("FAIL disc_drop: got valid=%b ir=%h want 0", o_ir_valid, o_ir); end
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h40) begin
      fails++; $display("FAIL disc_next: got req=%b addr=%h want 1/00000040", o_mem_req, o_mem_addr); end
    repeat (10) tick(0, 32'h0);
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc) || ev.ir === 16'hBEEF || ev.ir === 16'hDEAD) begin
          fails++; $display("FAIL disc_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
  endtask

  task automatic test_pop_push_redirect();
    ev_t ev;
    bit first = 1;
    go_idle();
    ack_pct = 0;
    tick(1, 32'h300);
    ack_pct = 100;
    tick(0, 32'h0);
    tests++; if (o_ir_valid !== 1'b1 || o_mem_req !== 1'b1 || o_mem_addr !== 32'h304) begin
      fails++; $display("FAIL ppr_setup: got valid=%b req=%b addr=%h want 1/1/00000304", o_ir_valid, o_mem_req, o_mem_addr); end
    rdy_pct = 100;
    tick(1, 32'h200);
    tests++; if (o_ir_valid !== 1'b0) begin fails++; $display("FAIL ppr_empty: got valid %b want 0", o_ir_valid); end
    tests++; if (o_mem_req !== 1'b1 || o_mem_addr !== 32'h200) begin
      fails++; $display("FAIL ppr_req: got req=%b addr=%h want 1/00000200", o_mem_req, o_mem_addr); end
    repeat (10) tick(0, 32'h0);
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) begin m_pc = ev.pc & ~32'd1; first = (ev.pc == 32'h200); end
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL ppr_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        if (first && ev.pc !== 32'h200) begin
          fails++; $display("FAIL ppr_first: got pc=%h want 00000200", ev.pc);
        end
        if (ev.pc == 32'h200) first = 0;
        m_pc = m_pc + 32'd2;
      end
    end
  endtask

  task automatic test_wrap();
    ev_t ev;
    go_idle();
    ack_pct = 0;
    tick(1, 32'hFFFF_FFFC);
    ackq.delete();
    ack_pct = 100; rdy_pct = 100;
    repeat (12) tick(0, 32'h0);
    tests++; if (ackq.size() < 2 || ackq[0] !== 32'hFFFF_FFFC || ackq[1] !== 32'h0) begin
      fails++; $display("FAIL wrap_addr: got %0d words first=%h second=%h want FFFFFFFC then 0",
                        ackq.size(), (ackq.size() > 0) ? ackq[0] : 32'hX, (ackq.size() > 1) ? ackq[1] : 32'hX); end
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL wrap_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
  endtask

  task automatic test_reset_mid();
    ev_t ev;
    ack_pct = 0; rdy_pct = 50;
    for (int i = 0; i < 50 && !(o_mem_req && o_ir_valid); i++) tick(0, 32'h0);
    tests++; if (!(o_mem_req === 1'b1 && o_ir_valid === 1'b1)) begin
      fails++; $display("FAIL rst_setup: got req=%b valid=%b want 1/1", o_mem_req, o_ir_valid); end
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL rst_pre_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
    i_rst = 1'b0;
    #1;
    tests++; if (o_mem_req !== 1'b0 || o_ir_valid !== 1'b0) begin
      fails++; $display("FAIL rst_async: got req=%b valid=%b want 0/0", o_mem_req, o_ir_valid); end
    tests++; if (o_mem_addr !== 32'h0 || o_ir !== 16'h0 || o_ir_pc !== 32'h0) begin
      fails++; $display("FAIL rst_values: got addr=%h ir=%h pc=%h want 0/0/0", o_mem_addr, o_ir, o_ir_pc); end
    p_hold_req = 0; p_hold_ir = 0;
    ack_pct = 100; rdy_pct = 100;
    repeat (2) tick(0, 32'h0);
    i_rst = 1'b1;
    m_pc = 32'h0;
    ackq.delete();
    repeat (12) tick(0, 32'h0);
    tests++; if (ackq.size() < 1 || ackq[0] !== 32'h0) begin
      fails++; $display("FAIL rst_restart: got %0d words first=%h want 00000000", ackq.size(), (ackq.size() > 0) ? ackq[0] : 32'hX); end
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL rst_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
  endtask

  task automatic test_random();
    ev_t ev;
    int n = 0;
    logic [31:0] rpc;
    ack_pct = 60; rdy_pct = 70;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(99) < 4) begin
        rpc = ($urandom_range(7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : ($urandom & 32'h0000_FFFF);
        tick(1, rpc);
      end else begin
        tick(0, 32'h0);
      end
    end
    while (evq.size() > 0) begin
      ev = evq.pop_front();
      if (ev.redir) m_pc = ev.pc & ~32'd1;
      else begin
        tests++; n++;
        if (ev.pc !== m_pc || ev.ir !== mem_half(m_pc)) begin
          fails++; $display("FAIL rand_stream: got pc=%h ir=%h want pc=%h ir=%h", ev.pc, ev.ir, m_pc, mem_half(m_pc));
        end
        m_pc = m_pc + 32'd2;
      end
    end
    tests++; if (n < 200) begin fails++; $display("FAIL rand_throughput: got %0d pops want >=200", n); end
    tests++; if (req_hold_err != 0) begin fails++; $display("FAIL req_stable: got %0d violations want 0", req_hold_err); end
    tests++; if (align_err != 0) begin fails++; $display("FAIL addr_align: got %0d violations want 0", align_err); end
    tests++; if (ir_hold_err != 0) begin fails++; $display("FAIL ir_stable: got %0d violations want 0", ir_hold_err); end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_odd();
    test_discard();
    test_pop_push_redirect();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
